slt_compare_unit: RTL and testbench

SLT_COMPARE_UNIT -- requirements
Module: slt_compare_unit

---
 rtl/slt_compare_unit_pkg.sv | 20 ++
 rtl/slt_compare_unit_if.sv | 36 +++
 rtl/slt_compare_unit_cmp_chunk.sv | 15 +
 rtl/slt_compare_unit.sv | 128 ++++++++++++
 tb/tb_slt_compare_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/slt_compare_unit_pkg.sv
// Shared types and constants for the chunked SLT/SLTU compare unit.
// Operand bias helper maps signed order onto unsigned order.
package compare_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic [XLEN-1:0] bias(
    input logic [XLEN-1:0] v,
    input logic            uns
  );
    return uns ? v : {~v[XLEN-1], v[XLEN-2:0]};
  endfunction

endpackage

// File: rtl/slt_compare_unit_if.sv
// Operand/result handshake bundle of the compare unit.
// The unit is the slave; the issuing stage is the master.
interface slt_compare_unit_if;
  import compare_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            is_unsigned;
  logic            out_valid;
  logic            out_ready;
  logic            lt;

  modport slave (
    input  in_valid,
    input  op_a,
    input  op_b,
    input  is_unsigned,
    input  out_ready,
    output in_ready,
    output out_valid,
    output lt
  );

  modport master (
    output in_valid,
    output op_a,
    output op_b,
    output is_unsigned,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  lt
  );
endinterface

// File: rtl/slt_compare_unit_cmp_chunk.sv
// Combinational unsigned compare of one chunk pair.
// Produces equality and less-than for the MSB-first walk.
module cmp_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq,
  output logic         o_lt
);

  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a < i_b);

endmodule

// File: rtl/slt_compare_unit.sv
// Multi-cycle SLT/SLTU comparator walking CHUNK_W bits per cycle,
// MSB-first, stopping at the first differing chunk.
module slt_compare_unit
  import compare_pkg::*;
#(
  parameter int CHUNK_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  slt_compare_unit_if.slave bus
);

  localparam int NCHUNK = XLEN / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   w_a_nxt;
  logic [XLEN-1:0]   w_b_nxt;
  logic              r_uns;
  logic              w_uns_nxt;
  logic              r_lt;
  logic              w_lt_nxt;

  logic [XLEN-1:0]    w_ka;
  logic [XLEN-1:0]    w_kb;
  logic [CHUNK_W-1:0] w_ca;
  logic [CHUNK_W-1:0] w_cb;
  logic               w_eq;
  logic               w_clt;

  assign w_ka = bias(r_a, r_uns);
  assign w_kb = bias(r_b, r_uns);

  always_comb begin
    w_ca = '0;
    w_cb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_ca = w_ka[XLEN-1-i*CHUNK_W -: CHUNK_W];
        w_cb = w_kb[XLEN-1-i*CHUNK_W -: CHUNK_W];
      end
    end
  end

  cmp_chunk #(
    .W (CHUNK_W)
  ) u_cmp (
    .i_a  (w_ca),
    .i_b  (w_cb),
    .o_eq (w_eq),
    .o_lt (w_clt)
  );

  assign bus.in_ready  = (r_state == IDLE) && rst_n;
  assign bus.out_valid = (r_state == DONE);
  assign bus.lt        = r_lt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_uns   <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_uns   <= w_uns_nxt;
      r_lt    <= w_lt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_uns_nxt   = r_uns;
    w_lt_nxt    = r_lt;
    if (flush) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
      w_lt_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            w_a_nxt     = bus.op_a;
            w_b_nxt     = bus.op_b;
            w_uns_nxt   = bus.is_unsigned;
            w_idx_nxt   = '0;
            w_state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (!w_eq) begin
            w_lt_nxt    = w_clt;
            w_state_nxt = DONE;
          end else if (r_idx == LAST) begin
            w_lt_nxt    = 1'b0;
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slt_compare_unit.sv
// Self-checking bench: directed table, corner sequences and
// random operands against an arithmetic reference model.
module tb_slt_compare_unit;

  localparam int W = 8;
  localparam int N = 32 / W;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;

  slt_compare_unit_if bus ();

  slt_compare_unit #(
    .CHUNK_W (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        u;
    logic        lt;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic ref_lt(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic u);
    if (u) return a < b;
    return $signed(a) < $signed(b);
  endfunction

  function automatic int ref_lat(input logic [31:0] a,
                                 input logic [31:0] b);
    logic [31:0] x;
    int msb;
    x = a ^ b;
    if (x == 0) return N;
    msb = 0;
    for (int i = 0; i < 32; i++) if (x[i]) msb = i;
    return (31 - msb) / W + 1;
  endfunction

  // called at a negedge with the unit idle
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic u, output logic got_lt,
                       output int lat);
    bus.op_a        = a;
    bus.op_b        = b;
    bus.is_unsigned = u;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got_lt = bus.lt;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [31:0] a,
                         input logic [31:0] b, input logic u,
                         input logic elt, input int elat);
    logic got;
    int   lat;
    chk({name, "_rdy"}, 32'(bus.in_ready), 32'd1);
    issue(a, b, u, got, lat);
    chk({name, "_lat"}, lat, elat);
    chk({name, "_lt"}, 32'(got), 32'(elt));
    consume();
    chk({name, "_idle"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic got;
    logic held;
    int   lat;
    int   seen;
    logic [31:0] a;
    logic [31:0] b;
    logic u;

    checks = 0;
    errors = 0;
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 1};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1};
    tbl[2] = '{32'h12345678, 32'h12345678, 1'b0, 1'b0, 4};
    tbl[3] = '{32'h00000010, 32'h00000011, 1'b1, 1'b1, 4};
    tbl[4] = '{32'h80000000, 32'h00000000, 1'b0, 1'b1, 1};
    tbl[5] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1};
    tbl[6] = '{32'h00010000, 32'h00020000, 1'b1, 1'b1, 2};
    tbl[7] = '{32'hFFFFFF00, 32'hFFFFFF01, 1'b0, 1'b1, 4};
    tbl[8] = '{32'h00000100, 32'h00000001, 1'b1, 1'b0, 3};
    tbl[9] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 4};

    rst_n           = 1'b0;
    flush           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.is_unsigned = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(bus.in_ready), 32'd0);
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    chk("rst_lt", 32'(bus.lt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b,
              tbl[i].u, tbl[i].lt, tbl[i].lat);
    end

    // backpressure: hold in DONE, stray in_valid must be ignored
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, held, lat);
    chk("bp_lat", lat, 1);
    chk("bp_lt0", 32'(held), 32'd1);
    bus.op_a        = 32'h0;
    bus.op_b        = 32'hFFFFFFFF;
    bus.is_unsigned = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("bp_ov%0d", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_lt%0d", c), 32'(bus.lt), 32'(held));
      chk($sformatf("bp_rdy%0d", c), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    consume();
    chk("bp_done_ov", 32'(bus.out_valid), 32'd0);
    chk("bp_done_rdy", 32'(bus.in_ready), 32'd1);

    // flush in the second BUSY cycle of an all-equal compare
    bus.op_a        = 32'h0;
    bus.op_b        = 32'h0;
    bus.is_unsigned = 1'b0;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_rdy", 32'(bus.in_ready), 32'd1);
    chk("fl_lt", 32'(bus.lt), 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    chk("fl_never_ov", seen, 0);
    run_vec("fl_next", 32'h80000000, 32'h0, 1'b0, 1'b1, 1);

    // flush beats acceptance in IDLE
    bus.op_a     = 32'h1;
    bus.op_b     = 32'h2;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    chk("fl_idle_noacc", seen, 0);

    // flush beats the output handshake and clears lt
    issue(32'h80000000, 32'h0, 1'b0, got, lat);
    chk("fl_done_lt", 32'(got), 32'd1);
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    chk("fl_done_ov", 32'(bus.out_valid), 32'd0);
    chk("fl_done_lt0", 32'(bus.lt), 32'd0);

    // reset while holding a result in DONE
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, got, lat);
    chk("rd_ov", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("rd_rdy_low", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rd_ov0", 32'(bus.out_valid), 32'd0);
    chk("rd_lt0", 32'(bus.lt), 32'd0);
    chk("rd_rdy", 32'(bus.in_ready), 32'd1);

    // random operands, many sharing long prefixes
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = a;
        2: b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = a ^ ($urandom & ((32'h1 << $urandom_range(0, 31)) - 1));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        a = a ^ 32'h80000000;
      end
      u = 1'($urandom_range(0, 1));
      issue(a, b, u, got, lat);
      checks++;
      if (lat != ref_lat(a, b) || got !== ref_lt(a, b, u)) begin
        errors++;
        $display("FAIL rnd%0d a=%h b=%h u=%0d lt=%0d/%0d lat=%0d/%0d",
                 i, a, b, u, got, ref_lt(a, b, u), lat, ref_lat(a, b));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      consume();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
